cascade_digit_counter: RTL and testbench
========================================

// Module: cascade_digit_counter
// PURPOSE
//  Parametrised multi-digit counter chain for the stopwatch time base. Each digit
//  is 4 bits wide and has its own radix, so one instance can count mm:ss.cc.
//  The block counts up or down, supports parallel load and synchronous clear,
//  and can either wrap or saturate at the terminal value.
//  It is driven by the tick enable from the prescaler and feeds the display mux.
// PARAMETERS
//  NUM_DIGITS   6          number of cascaded digits (1..8); digit 0 is the LSB
//  DIGIT_BASES  24'h6A6AAA packed radix per digit, 4 bits each, digit i at [4i+3:4i];
//                          legal values 2..15; default gives mm:ss.cc
//  WRAP_MODE    1          1 = wrap at terminal; 0 = saturate (hold) at terminal
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  clear        in   1      synchronous clear to all-zero
//  load         in   1      synchronous parallel load of load_value
//  load_value   in   4*N    per-digit load value, same packing as count
//  enable       in   1      count tick, one-cycle qualifier
//  up_down      in   1      1 = count up; 0 = count down
//  count        out  4*N    registered digit values
//  carry_out    out  1      registered pulse: the chain wrapped on this edge
//  at_terminal  out  1      decode of count: all digits at terminal for current up_down
//  load_err     out  1      registered pulse: load contained an out-of-range digit
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, carry_out=0, load_err=0. Release is
//    synchronous to clk; the first action is on the first rising edge after release.
//  - Priority per edge: clear > load > enable count > hold.
//    Control inputs not selected on an edge are ignored on that edge.
//  - clear: count <= 0 and carry_out <= 0. load_err <= 0.
//  - load: digit i <= load_value[i] if load_value[i] < base_i; otherwise <= 0.
//    load_err <= 1 for one cycle if any digit was replaced. carry_out <= 0.
//  - Count step, enable=1 and no clear/load:
//    * Up: digit i increments iff every digit j<i equals base_j-1.
//      A digit at base_i-1 that increments becomes 0.
//    * Down: digit i decrements iff every digit j<i equals 0.
//      A digit at 0 that decrements becomes base_i-1.
//    * The whole chain resolves in one cycle, with no ripple latency across digits.
//  - Terminal value: all digits at base-1 when up; all digits 0 when down.
//  - A step taken from the terminal value:
//    * WRAP_MODE=1: count goes to all-zero (up) or all-max (down), and
//      carry_out=1 for exactly the one cycle following that edge.
//    * WRAP_MODE=0: count holds and carry_out stays 0.
//  - carry_out and load_err are 0 on every edge that does not set them.
//  - at_terminal is combinational from count and up_down; it is valid in hold too.
//  - Changing up_down mid-run is legal. The new direction applies at the next enabled edge.
//  - Width: only the 4*NUM_DIGITS count bits are used. Count never holds a
//    digit >= its base after reset, clear, load or step.
// TESTING (defaults unless stated)
//  1 Reset then 12 enable pulses, up.
//    -> count=24'h000012; carry_out never asserted.
//  2 load 24'h595998, then 2 enables, up.
//    -> 595999, then 000000 with carry_out=1 for one cycle only.
//  3 WRAP_MODE=0: load 24'h595999, 3 enables, up.
//    -> count stays 595999; at_terminal=1; carry_out=0.
//  4 Down from 000000, 1 enable.
//    -> 595999 with carry_out=1. A second enable gives 595998.
//  5 load 24'h0A00C7.
//    -> count=000007; load_err=1 for one cycle.
//  6 clear, load and enable together -> count=0.
//    rst low mid-run -> count=0 immediately, before any clk edge.

Source files
------------

// File: rtl/cascade_digit_counter.sv
// cascade_digit_counter
// Multi-digit BCD-style counter chain for the stopwatch time base. Each
// 4-bit digit has its own radix (packed into DIGIT_BASES), so the default
// instance counts mm:ss.cc. The chain counts up or down on the prescaler
// tick, supports synchronous clear and parallel load, and either wraps or
// saturates at the terminal value. All digits resolve in a single cycle:
// the carry/borrow decision for every digit is a prefix AND over the
// lower digits, not a registered ripple.

module cascade_digit_counter #(
    parameter int                      NUM_DIGITS  = 6,
    parameter logic [4*NUM_DIGITS-1:0] DIGIT_BASES = 24'h6A6AAA,
    parameter int                      WRAP_MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    enable,
    input  logic                    up_down,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    carry_out,
    output logic                    at_terminal,
    output logic                    load_err
);

    localparam int   W        = 4 * NUM_DIGITS;
    localparam logic SATURATE = (WRAP_MODE == 0);

    // Architectural state
    logic [W-1:0]          r_count;
    logic                  r_carryOut;
    logic                  r_loadErr;

    // Per-digit view of the radix and current value
    logic [3:0]            w_base   [NUM_DIGITS];
    logic [3:0]            w_maxVal [NUM_DIGITS];
    logic [3:0]            w_cur    [NUM_DIGITS];
    logic [3:0]            w_ldDigit[NUM_DIGITS];

    // Per-digit flags
    logic [NUM_DIGITS-1:0] w_isMax;
    logic [NUM_DIGITS-1:0] w_isZero;
    logic [NUM_DIGITS-1:0] w_upMove;
    logic [NUM_DIGITS-1:0] w_dnMove;
    logic [NUM_DIGITS-1:0] w_loadOk;

    // Candidate next values for the whole chain
    logic [W-1:0]          w_upCount;
    logic [W-1:0]          w_dnCount;
    logic [W-1:0]          w_stepCount;
    logic [W-1:0]          w_loadCount;

    // Chain-level decodes
    logic                  w_allMax;
    logic                  w_allZero;
    logic                  w_atTerminal;
    logic                  w_satHold;
    logic                  w_anyBadDigit;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            assign w_base[g]    = DIGIT_BASES[4*g +: 4];
            assign w_maxVal[g]  = w_base[g] - 4'd1;
            assign w_cur[g]     = r_count[4*g +: 4];
            assign w_ldDigit[g] = load_value[4*g +: 4];

            assign w_isMax[g]   = (w_cur[g] == w_maxVal[g]);
            assign w_isZero[g]  = (w_cur[g] == 4'd0);

            // Counting up: a digit at its top value rolls to zero when it moves
            assign w_upCount[4*g +: 4] = w_upMove[g]
                                       ? (w_isMax[g] ? 4'd0 : w_cur[g] + 4'd1)
                                       : w_cur[g];

            // Counting down: a digit at zero rolls to its top value when it moves
            assign w_dnCount[4*g +: 4] = w_dnMove[g]
                                       ? (w_isZero[g] ? w_maxVal[g] : w_cur[g] - 4'd1)
                                       : w_cur[g];

            // Out-of-range load digits are forced to zero so count stays legal
            assign w_loadOk[g]            = (w_ldDigit[g] < w_base[g]);
            assign w_loadCount[4*g +: 4]  = w_loadOk[g] ? w_ldDigit[g] : 4'd0;
        end
    endgenerate

    // Prefix AND over lower digits: a digit moves only when all lower digits roll over
    always_comb begin : p_chain
        logic upAcc;
        logic dnAcc;
        upAcc    = 1'b1;
        dnAcc    = 1'b1;
        w_upMove = '0;
        w_dnMove = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_upMove[i] = upAcc;
            w_dnMove[i] = dnAcc;
            upAcc       = upAcc & w_isMax[i];
            dnAcc       = dnAcc & w_isZero[i];
        end
    end

    assign w_allMax      = &w_isMax;
    assign w_allZero     = &w_isZero;
    assign w_atTerminal  = up_down ? w_allMax : w_allZero;
    assign w_satHold     = w_atTerminal & SATURATE;
    assign w_anyBadDigit = ~(&w_loadOk);
    assign w_stepCount   = up_down ? w_upCount : w_dnCount;

    // Counter state update with priority clear > load > enabled step > hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_carryOut <= 1'b0;
            r_loadErr  <= 1'b0;
        end else if (clear) begin
            r_count    <= '0;
            r_carryOut <= 1'b0;
            r_loadErr  <= 1'b0;
        end else if (load) begin
            r_count    <= w_loadCount;
            r_carryOut <= 1'b0;
            r_loadErr  <= w_anyBadDigit;
        end else if (enable) begin
            if (!w_satHold) begin
                r_count <= w_stepCount;
            end
            r_carryOut <= w_atTerminal & ~SATURATE;
            r_loadErr  <= 1'b0;
        end else begin
            r_carryOut <= 1'b0;
            r_loadErr  <= 1'b0;
        end
    end

    assign count       = r_count;
    assign carry_out   = r_carryOut;
    assign load_err    = r_loadErr;
    assign at_terminal = w_atTerminal;

endmodule

// File: tb/tb_cascade_digit_counter.sv
// Testbench for cascade_digit_counter. Two instances (wrapping and
// saturating) share one set of inputs. The reference model keeps the whole
// chain as a single integer in mixed radix and derives digits by div/mod.

module tb_cascade_digit_counter;

    localparam int          ND    = 6;
    localparam logic [23:0] BASES = 24'h6A6AAA;
    localparam int          MODV  = 360000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        clear      = 1'b0;
    logic        load       = 1'b0;
    logic [23:0] load_value = '0;
    logic        enable     = 1'b0;
    logic        up_down    = 1'b1;

    logic [23:0] countW, countS;
    logic        carryW, carryS, termW, termS, errW, errS;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = wrapping instance, 1 = saturating instance
    int mVal  [2];
    bit mCarry[2];
    bit mErr  [2];

    always #5 clk = ~clk;

    cascade_digit_counter #(.NUM_DIGITS(ND), .DIGIT_BASES(BASES), .WRAP_MODE(1)) dutWrap (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .count(countW), .carry_out(carryW),
        .at_terminal(termW), .load_err(errW)
    );

    cascade_digit_counter #(.NUM_DIGITS(ND), .DIGIT_BASES(BASES), .WRAP_MODE(0)) dutSat (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .count(countS), .carry_out(carryS),
        .at_terminal(termS), .load_err(errS)
    );

    function automatic int baseOf(input int i);
        logic [23:0] b;
        b = BASES;
        return int'(b[4*i +: 4]);
    endfunction

    function automatic logic [23:0] toPacked(input int v);
        logic [23:0] p;
        int r;
        p = '0;
        r = v;
        for (int i = 0; i < ND; i++) begin
            p[4*i +: 4] = 4'(r % baseOf(i));
            r = r / baseOf(i);
        end
        return p;
    endfunction

    function automatic int loadedValue(input logic [23:0] lv);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < ND; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d >= baseOf(i)) d = 0;
            v = v + d * w;
            w = w * baseOf(i);
        end
        return v;
    endfunction

    function automatic bit loadHasBad(input logic [23:0] lv);
        bit b;
        b = 1'b0;
        for (int i = 0; i < ND; i++)
            if (int'(lv[4*i +: 4]) >= baseOf(i)) b = 1'b1;
        return b;
    endfunction

    function automatic bit expTerm(input int v, input bit ud);
        return ud ? (v == MODV - 1) : (v == 0);
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                mVal[k] = 0; mCarry[k] = 0; mErr[k] = 0;
            end else if (load) begin
                mVal[k] = loadedValue(load_value); mCarry[k] = 0; mErr[k] = loadHasBad(load_value);
            end else if (enable) begin
                mErr[k] = 0;
                if (expTerm(mVal[k], up_down)) begin
                    if (k == 0) begin
                        mVal[k]   = up_down ? 0 : MODV - 1;
                        mCarry[k] = 1;
                    end else begin
                        mCarry[k] = 0;
                    end
                end else begin
                    mVal[k]   = up_down ? mVal[k] + 1 : mVal[k] - 1;
                    mCarry[k] = 0;
                end
            end else begin
                mCarry[k] = 0; mErr[k] = 0;
            end
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mVal[k] = 0; mCarry[k] = 0; mErr[k] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, update model at the rising edge
    task automatic applyStimulus(input logic c, input logic l, input logic [23:0] lv,
                                 input logic e, input logic ud);
        @(negedge clk);
        clear = c; load = l; load_value = lv; enable = e; up_down = ud;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        modelReset();
        total++; if (countW !== 24'h0) begin bad++; $display("FAIL reset_countW got=%h exp=%h", countW, 24'h0); end
        total++; if (countS !== 24'h0) begin bad++; $display("FAIL reset_countS got=%h exp=%h", countS, 24'h0); end
        total++; if (carryW !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carryW); end
        total++; if (errW !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", errW); end
        up_down = 1'b1; #1;
        total++; if (termW !== 1'b0) begin bad++; $display("FAIL reset_term_up got=%b exp=0", termW); end
        up_down = 1'b0; #1;
        total++; if (termW !== 1'b1) begin bad++; $display("FAIL reset_term_dn got=%b exp=1", termW); end
        up_down = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 24'h0, 1, 1);
            total++; if (carryW !== 1'b0) begin bad++; $display("FAIL up12_carry step=%0d got=%b exp=0", i, carryW); end
        end
        total++; if (countW !== 24'h000012) begin bad++; $display("FAIL up12_count got=%h exp=%h", countW, 24'h000012); end
        total++; if (countS !== 24'h000012) begin bad++; $display("FAIL up12_countS got=%h exp=%h", countS, 24'h000012); end
    endtask

    task automatic test_wrap_up();
        applyStimulus(0, 1, 24'h595998, 0, 1);
        total++; if (countW !== 24'h595998) begin bad++; $display("FAIL wrap_load got=%h exp=%h", countW, 24'h595998); end
        applyStimulus(0, 0, 24'h0, 1, 1);
        total++; if (countW !== 24'h595999) begin bad++; $display("FAIL wrap_step1 got=%h exp=%h", countW, 24'h595999); end
        total++; if (carryW !== 1'b0) begin bad++; $display("FAIL wrap_step1_carry got=%b exp=0", carryW); end
        total++; if (termW !== 1'b1) begin bad++; $display("FAIL wrap_step1_term got=%b exp=1", termW); end
        applyStimulus(0, 0, 24'h0, 1, 1);
        total++; if (countW !== 24'h000000) begin bad++; $display("FAIL wrap_step2 got=%h exp=%h", countW, 24'h0); end
        total++; if (carryW !== 1'b1) begin bad++; $display("FAIL wrap_step2_carry got=%b exp=1", carryW); end
        total++; if (countS !== 24'h595999) begin bad++; $display("FAIL wrap_sat_hold got=%h exp=%h", countS, 24'h595999); end
        applyStimulus(0, 0, 24'h0, 0, 1);
        total++; if (carryW !== 1'b0) begin bad++; $display("FAIL wrap_carry_pulse got=%b exp=0", carryW); end
        total++; if (countW !== 24'h000000) begin bad++; $display("FAIL wrap_hold got=%h exp=%h", countW, 24'h0); end
    endtask

    task automatic test_saturate();
        applyStimulus(0, 1, 24'h595999, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 24'h0, 1, 1);
            total++; if (countS !== 24'h595999) begin bad++; $display("FAIL sat_count step=%0d got=%h exp=%h", i, countS, 24'h595999); end
            total++; if (carryS !== 1'b0) begin bad++; $display("FAIL sat_carry step=%0d got=%b exp=0", i, carryS); end
            total++; if (termS !== 1'b1) begin bad++; $display("FAIL sat_term step=%0d got=%b exp=1", i, termS); end
        end
    endtask

    task automatic test_down_wrap();
        applyStimulus(1, 0, 24'h0, 0, 0);
        applyStimulus(0, 0, 24'h0, 1, 0);
        total++; if (countW !== 24'h595999) begin bad++; $display("FAIL down_wrap got=%h exp=%h", countW, 24'h595999); end
        total++; if (carryW !== 1'b1) begin bad++; $display("FAIL down_wrap_carry got=%b exp=1", carryW); end
        total++; if (countS !== 24'h000000) begin bad++; $display("FAIL down_sat got=%h exp=%h", countS, 24'h0); end
        total++; if (carryS !== 1'b0) begin bad++; $display("FAIL down_sat_carry got=%b exp=0", carryS); end
        total++; if (termS !== 1'b1) begin bad++; $display("FAIL down_sat_term got=%b exp=1", termS); end
        applyStimulus(0, 0, 24'h0, 1, 0);
        total++; if (countW !== 24'h595998) begin bad++; $display("FAIL down_step2 got=%h exp=%h", countW, 24'h595998); end
        total++; if (carryW !== 1'b0) begin bad++; $display("FAIL down_step2_carry got=%b exp=0", carryW); end
    endtask

    task automatic test_load_err();
        applyStimulus(0, 1, 24'h0A00C7, 0, 1);
        total++; if (countW !== 24'h000007) begin bad++; $display("FAIL loaderr_count got=%h exp=%h", countW, 24'h000007); end
        total++; if (errW !== 1'b1) begin bad++; $display("FAIL loaderr_flag got=%b exp=1", errW); end
        total++; if (errS !== 1'b1) begin bad++; $display("FAIL loaderr_flagS got=%b exp=1", errS); end
        applyStimulus(0, 0, 24'h0, 0, 1);
        total++; if (errW !== 1'b0) begin bad++; $display("FAIL loaderr_pulse got=%b exp=0", errW); end
        total++; if (countW !== 24'h000007) begin bad++; $display("FAIL loaderr_hold got=%h exp=%h", countW, 24'h000007); end
    endtask

    task automatic test_priority();
        applyStimulus(0, 0, 24'h0, 1, 1);
        applyStimulus(1, 1, 24'h123456, 1, 1);
        total++; if (countW !== 24'h0) begin bad++; $display("FAIL prio_clear got=%h exp=%h", countW, 24'h0); end
        applyStimulus(0, 1, 24'h000123, 1, 1);
        total++; if (countW !== 24'h000123) begin bad++; $display("FAIL prio_load got=%h exp=%h", countW, 24'h000123); end
        applyStimulus(0, 1, 24'hFFFFFF, 0, 1);
        total++; if (errW !== 1'b1) begin bad++; $display("FAIL prio_err_set got=%b exp=1", errW); end
        applyStimulus(1, 1, 24'hFFFFFF, 0, 1);
        total++; if (errW !== 1'b0) begin bad++; $display("FAIL prio_clear_err got=%b exp=0", errW); end
    endtask

    task automatic test_async_reset();
        applyStimulus(0, 1, 24'h120345, 0, 1);
        applyStimulus(0, 0, 24'h0, 1, 1);
        @(negedge clk);
        enable = 1'b0; load = 1'b0; clear = 1'b0;
        #2 rst = 1'b0;
        #1;
        modelReset();
        total++; if (countW !== 24'h0) begin bad++; $display("FAIL async_countW got=%h exp=%h", countW, 24'h0); end
        total++; if (countS !== 24'h0) begin bad++; $display("FAIL async_countS got=%h exp=%h", countS, 24'h0); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic        c, l, e, ud;
        logic [23:0] lv;
        int          pick;
        for (int n = 0; n < 500; n++) begin
            c  = ($urandom_range(0, 99) < 3);
            l  = ($urandom_range(0, 99) < 8);
            e  = ($urandom_range(0, 99) < 75);
            ud = ($urandom_range(0, 99) < 55);
            pick = $urandom_range(0, 9);
            if (pick == 0)      lv = 24'h595999;
            else if (pick == 1) lv = 24'h595997;
            else if (pick == 2) lv = 24'h000001;
            else                lv = 24'($urandom);
            applyStimulus(c, l, lv, e, ud);
            total++; if (countW !== toPacked(mVal[0])) begin bad++; $display("FAIL rnd_countW n=%0d got=%h exp=%h", n, countW, toPacked(mVal[0])); end
            total++; if (countS !== toPacked(mVal[1])) begin bad++; $display("FAIL rnd_countS n=%0d got=%h exp=%h", n, countS, toPacked(mVal[1])); end
            total++; if (carryW !== mCarry[0]) begin bad++; $display("FAIL rnd_carryW n=%0d got=%b exp=%b", n, carryW, mCarry[0]); end
            total++; if (carryS !== mCarry[1]) begin bad++; $display("FAIL rnd_carryS n=%0d got=%b exp=%b", n, carryS, mCarry[1]); end
            total++; if (errW !== mErr[0]) begin bad++; $display("FAIL rnd_errW n=%0d got=%b exp=%b", n, errW, mErr[0]); end
            total++; if (termW !== expTerm(mVal[0], ud)) begin bad++; $display("FAIL rnd_termW n=%0d got=%b exp=%b", n, termW, expTerm(mVal[0], ud)); end
            total++; if (termS !== expTerm(mVal[1], ud)) begin bad++; $display("FAIL rnd_termS n=%0d got=%b exp=%b", n, termS, expTerm(mVal[1], ud)); end
        end
    endtask

    initial begin
        $display("[TB] cascade_digit_counter bench start");
        test_reset();
        test_count_up();
        test_wrap_up();
        test_saturate();
        test_down_wrap();
        test_load_err();
        test_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
